random_delay_timer: RTL and testbench

Parametrised random-delay generator for the reaction-game datapath. A free-running 32-bit Galois LFSR draws a delay of MIN_DELAY + (lfsr mod (SPAN+1)) cycles, and a down-counter times it out. The block supports one-shot and periodic (auto-rearm) modes, abort, runtime reseeding and a live remaining-count output. It sits between the game FSM (which issues iSTART/iABORT) and the stimulus LED/scoring logic (which consumes oDONE).

---
 rtl/random_delay_timer_if.sv | 25 ++
 rtl/random_delay_timer.sv | 115 +++++++++++
 tb/tb_random_delay_timer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/random_delay_timer_if.sv
// Control/status bundle between the game FSM (master), the random delay timer (slave)
// and the stimulus/scoring logic that watches oDONE.
interface random_delay_timer_if #(
  parameter int WIDTH = 27
);
  logic             iSTART;
  logic             iMODE;
  logic             iABORT;
  logic             iSEED_LD;
  logic [31:0]      iSEED;
  logic             oBUSY;
  logic             oDONE;
  logic [WIDTH-1:0] oDELAY;
  logic [WIDTH-1:0] oREMAIN;

  modport master (
    output iSTART, iMODE, iABORT, iSEED_LD, iSEED,
    input  oBUSY, oDONE, oDELAY, oREMAIN
  );

  modport slave (
    input  iSTART, iMODE, iABORT, iSEED_LD, iSEED,
    output oBUSY, oDONE, oDELAY, oREMAIN
  );
endinterface

// File: rtl/random_delay_timer.sv
// Random-delay generator: a free-running Galois LFSR picks MIN + (lfsr mod (SPAN+1)) cycles,
// then a down-counter times it out in one-shot or periodic mode.
module random_delay_timer #(
  parameter int          WIDTH     = 27,
  parameter int          MIN_DELAY = 25_000_000,
  parameter int          SPAN      = 75_000_000,
  parameter int          SIM_MODE  = 0,
  parameter logic [31:0] LFSR_SEED = 32'h1ABCDE7,
  parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
  input logic                 iCLK,
  input logic                 iRST,
  random_delay_timer_if.slave bus
);

  localparam int unsigned EFF_MIN  = (SIM_MODE != 0) ? 1000 : MIN_DELAY;
  localparam int unsigned EFF_SPAN = (SIM_MODE != 0) ? 3000 : SPAN;
  localparam logic [31:0] MODULUS  = EFF_SPAN + 32'd1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [31:0]      r_lfsr;
  logic [WIDTH-1:0] r_remain;
  logic [WIDTH-1:0] r_delay;
  logic             r_done;
  logic             r_periodic;

  logic [WIDTH-1:0] w_nextRemain;
  logic [WIDTH-1:0] w_nextDelay;
  logic             w_nextDone;
  logic             w_nextPeriodic;
  logic [WIDTH-1:0] w_span;
  logic [WIDTH-1:0] w_draw;

  // The draw always uses the current (pre-step, pre-load) LFSR value.
  assign w_span = WIDTH'(r_lfsr % MODULUS);
  assign w_draw = WIDTH'(EFF_MIN) + w_span;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_lfsr <= LFSR_SEED;
    end else if (bus.iSEED_LD) begin
      r_lfsr <= (bus.iSEED == 32'd0) ? LFSR_SEED : bus.iSEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_POLY : 32'd0);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= IDLE;
      r_remain   <= '0;
      r_delay    <= WIDTH'(EFF_MIN);
      r_done     <= 1'b0;
      r_periodic <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_remain   <= w_nextRemain;
      r_delay    <= w_nextDelay;
      r_done     <= w_nextDone;
      r_periodic <= w_nextPeriodic;
    end
  end

  // Abort outranks expiry, so a cancelled delay never produces a done pulse.
  always_comb begin
    w_nextState    = r_state;
    w_nextRemain   = r_remain;
    w_nextDelay    = r_delay;
    w_nextDone     = 1'b0;
    w_nextPeriodic = r_periodic;
    case (r_state)
      IDLE: begin
        if (bus.iSTART && !bus.iABORT) begin
          w_nextState    = RUN;
          w_nextDelay    = w_draw;
          w_nextRemain   = w_draw;
          w_nextPeriodic = bus.iMODE;
        end
      end
      RUN: begin
        if (bus.iABORT) begin
          w_nextState  = IDLE;
          w_nextRemain = '0;
        end else if (r_remain > WIDTH'(1)) begin
          w_nextRemain = r_remain - WIDTH'(1);
        end else begin
          w_nextDone = 1'b1;
          if (r_periodic) begin
            w_nextDelay  = w_draw;
            w_nextRemain = w_draw;
          end else begin
            w_nextState  = IDLE;
            w_nextRemain = '0;
          end
        end
      end
      default: begin
        w_nextState  = IDLE;
        w_nextRemain = '0;
      end
    endcase
  end

  assign bus.oBUSY   = (r_state == RUN);
  assign bus.oDONE   = r_done;
  assign bus.oDELAY  = r_delay;
  assign bus.oREMAIN = r_remain;

endmodule

// File: tb/tb_random_delay_timer.sv
// Scoreboard bench for random_delay_timer: a small fixed-delay instance and a SIM_MODE instance,
// both checked every cycle against a deadline-based reference model.
module tb_random_delay_timer;

  localparam int          WIDTH = 16;
  localparam int          NDUT  = 2;
  localparam logic [31:0] SEED  = 32'h1ABCDE7;
  localparam logic [31:0] POLY  = 32'h80200003;

  typedef struct {
    int cycle;
    int delay;
  } doneItem_t;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic             rstV    [NDUT];
  logic             startV  [NDUT];
  logic             modeV   [NDUT];
  logic             abortV  [NDUT];
  logic             seedLdV [NDUT];
  logic [31:0]      seedV   [NDUT];
  logic             busyV   [NDUT];
  logic             doneV   [NDUT];
  logic [WIDTH-1:0] delayV  [NDUT];
  logic [WIDTH-1:0] remainV [NDUT];

  // Effective delay parameters: instance 1 runs in SIM_MODE, which overrides its MIN/SPAN.
  int minE  [NDUT] = '{4, 1000};
  int spanE [NDUT] = '{0, 3000};

  random_delay_timer_if #(.WIDTH(WIDTH)) busA ();
  random_delay_timer_if #(.WIDTH(WIDTH)) busB ();

  assign busA.iSTART   = startV[0];
  assign busA.iMODE    = modeV[0];
  assign busA.iABORT   = abortV[0];
  assign busA.iSEED_LD = seedLdV[0];
  assign busA.iSEED    = seedV[0];
  assign busyV[0]      = busA.oBUSY;
  assign doneV[0]      = busA.oDONE;
  assign delayV[0]     = busA.oDELAY;
  assign remainV[0]    = busA.oREMAIN;

  assign busB.iSTART   = startV[1];
  assign busB.iMODE    = modeV[1];
  assign busB.iABORT   = abortV[1];
  assign busB.iSEED_LD = seedLdV[1];
  assign busB.iSEED    = seedV[1];
  assign busyV[1]      = busB.oBUSY;
  assign doneV[1]      = busB.oDONE;
  assign delayV[1]     = busB.oDELAY;
  assign remainV[1]    = busB.oREMAIN;

  random_delay_timer #(
    .WIDTH(WIDTH), .MIN_DELAY(4), .SPAN(0), .SIM_MODE(0),
    .LFSR_SEED(SEED), .LFSR_POLY(POLY)
  ) dutA (
    .iCLK(iCLK), .iRST(rstV[0]), .bus(busA)
  );

  random_delay_timer #(
    .WIDTH(WIDTH), .MIN_DELAY(4), .SPAN(0), .SIM_MODE(1),
    .LFSR_SEED(SEED), .LFSR_POLY(POLY)
  ) dutB (
    .iCLK(iCLK), .iRST(rstV[1]), .bus(busB)
  );

  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mLfsr     [NDUT] = '{SEED, SEED};
  bit          mBusy     [NDUT] = '{0, 0};
  bit          mPeriodic [NDUT] = '{0, 0};
  int          mDelay    [NDUT] = '{4, 1000};
  int          mDeadline [NDUT] = '{0, 0};
  doneItem_t   doneQ0[$];
  doneItem_t   doneQ1[$];

  function automatic logic [31:0] lfsrStep(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? POLY : 32'h0);
  endfunction

  function automatic int drawDelay(input int k, input logic [31:0] l);
    logic [31:0] modulus;
    modulus = 32'(spanE[k] + 1);
    return minE[k] + int'(l % modulus);
  endfunction

  task automatic checkOutput(input string name, input int k, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s[dut%0d] cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name, input int k);
    checks++;
    errors++;
    $display("[TB] FAIL timeout %s[dut%0d] cycle %0d: got no event expected one", name, k, cyc);
  endtask

  // Reference model: a running timer is just an absolute deadline cycle; expiries are pushed to the scoreboard.
  always @(posedge iCLK) begin
    cyc++;
    for (int k = 0; k < NDUT; k++) begin
      int        d;
      doneItem_t item;
      d = drawDelay(k, mLfsr[k]);
      if (rstV[k]) begin
        mLfsr[k]  = SEED;
        mBusy[k]  = 1'b0;
        mDelay[k] = minE[k];
      end else begin
        if (mBusy[k]) begin
          if (abortV[k]) begin
            mBusy[k] = 1'b0;
          end else if (cyc == mDeadline[k]) begin
            if (mPeriodic[k]) begin
              mDelay[k]    = d;
              mDeadline[k] = mDeadline[k] + d;
            end else begin
              mBusy[k] = 1'b0;
            end
            item.cycle = cyc;
            item.delay = mDelay[k];
            if (k == 0) doneQ0.push_back(item);
            else        doneQ1.push_back(item);
          end
        end else if (startV[k] && !abortV[k]) begin
          mBusy[k]     = 1'b1;
          mPeriodic[k] = modeV[k];
          mDelay[k]    = d;
          mDeadline[k] = cyc + d;
        end
        mLfsr[k] = seedLdV[k] ? ((seedV[k] == 32'h0) ? SEED : seedV[k]) : lfsrStep(mLfsr[k]);
      end
    end
  end

  // Monitor: compares every output each cycle and pops the scoreboard when a done pulse is due.
  always @(negedge iCLK) begin
    for (int k = 0; k < NDUT; k++) begin
      int        expRemain;
      bit        expDone;
      doneItem_t it;
      expRemain = mBusy[k] ? (mDeadline[k] - cyc) : 0;
      expDone   = 1'b0;
      it.cycle  = 0;
      it.delay  = 0;
      if (k == 0 && doneQ0.size() > 0 && doneQ0[0].cycle == cyc) begin
        expDone = 1'b1;
        it      = doneQ0.pop_front();
      end else if (k == 1 && doneQ1.size() > 0 && doneQ1[0].cycle == cyc) begin
        expDone = 1'b1;
        it      = doneQ1.pop_front();
      end
      checkOutput("busy", k, busyV[k], mBusy[k]);
      checkOutput("remain", k, remainV[k], expRemain);
      checkOutput("delay", k, delayV[k], mDelay[k]);
      checkOutput("done", k, doneV[k], expDone);
      if (expDone) checkOutput("doneDelay", k, delayV[k], it.delay);
      if (k == 1 && busyV[1]) checkOutput("delayRange", k, (delayV[1] >= 1000 && delayV[1] <= 4000), 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic applyStimulus(input int k, input bit start, input bit mode, input bit abort,
                               input bit seedLd, input logic [31:0] seed);
    startV[k]  = start;
    modeV[k]   = mode;
    abortV[k]  = abort;
    seedLdV[k] = seedLd;
    seedV[k]   = seed;
    tick(1);
    startV[k]  = 1'b0;
    abortV[k]  = 1'b0;
    seedLdV[k] = 1'b0;
  endtask

  task automatic waitRemain(input int k, input int target);
    int n = 0;
    while (!(mBusy[k] && (mDeadline[k] - cyc) == target)) begin
      if (n == 6000) begin
        timeoutFail("waitRemain", k);
        return;
      end
      tick(1);
      n++;
    end
  endtask

  task automatic waitIdle(input int k);
    int n = 0;
    while (mBusy[k]) begin
      if (n == 6000) begin
        timeoutFail("waitIdle", k);
        return;
      end
      tick(1);
      n++;
    end
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rstV[k]    = 1'b1;
      startV[k]  = 1'b0;
      modeV[k]   = 1'b0;
      abortV[k]  = 1'b0;
      seedLdV[k] = 1'b0;
      seedV[k]   = 32'h0;
    end
    tick(3);
    rstV[0] = 1'b0;
    rstV[1] = 1'b0;
    tick(1);

    // Fixed 4-cycle instance: one-shot, periodic with abort, abort at expiry, ignored restarts.
    applyStimulus(0, 1, 0, 0, 0, 0);
    waitIdle(0);
    tick(2);
    applyStimulus(0, 1, 1, 0, 0, 0);
    tick(9);
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick(6);
    applyStimulus(0, 1, 0, 0, 0, 0);
    waitRemain(0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick(3);
    applyStimulus(0, 1, 0, 0, 0, 0);
    tick(1);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    waitIdle(0);
    tick(2);
    applyStimulus(0, 1, 0, 1, 0, 0);
    tick(2);
    applyStimulus(0, 1, 0, 0, 0, 0);
    waitIdle(0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    waitIdle(0);
    tick(2);

    // SIM_MODE instance: random start offsets with occasional random reseeds.
    for (int r = 0; r < 12; r++) begin
      tick($urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0) applyStimulus(1, 0, 0, 0, 1, $urandom);
      applyStimulus(1, 1, 0, 0, 0, 0);
      waitIdle(1);
    end
    applyStimulus(1, 1, 1, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      waitRemain(1, 1);
      tick(1);
    end
    applyStimulus(1, 0, 0, 1, 0, 0);
    tick(2);

    // Seed loads: zero seed falls back to the default, and a load alongside a start.
    applyStimulus(1, 0, 0, 0, 1, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitIdle(1);
    applyStimulus(1, 1, 0, 0, 1, 32'hDEADBEEF);
    waitIdle(1);
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitIdle(1);

    // Reset in the middle of a delay, then a fresh draw from the reset seed.
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitRemain(1, 2);
    rstV[1] = 1'b1;
    tick(1);
    rstV[1] = 1'b0;
    tick(3);
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitIdle(1);
    tick(2);

    checkOutput("pendingDone", 0, doneQ0.size(), 0);
    checkOutput("pendingDone", 1, doneQ1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
